fetch_unit: RTL and testbench

Instruction fetch stage that supplies the instruction word whose OPCode, funct3 and funct7 fields the control unit decodes. It owns the program counter and issues one-outstanding-request reads on the instruction-memory port. It buffers returned words in a 2-entry queue, presents them to decode under a stall signal, and flushes on branch/jump redirects.

---
 rtl/fetch_unit.sv | 150 +++++++++++++++
 tb/tb_fetch_unit.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues one outstanding imem read at a time,
// buffers returned words in a head+skid queue and flushes on redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] PCTarget,
    input  logic        stall,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemGnt,
    input  logic        imemRValid,
    input  logic [31:0] imemRData,
    output logic        instrValid,
    output logic [31:0] instr,
    output logic [31:0] instrPC,
    output logic [6:0]  OPCode,
    output logic [2:0]  funct3,
    output logic        funct7
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        discard_q, discard_d;
    logic        head_vld_q, head_vld_d;
    logic [31:0] head_instr_q, head_instr_d;
    logic [31:0] head_pc_q, head_pc_d;
    logic        skid_vld_q, skid_vld_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;

    logic [31:0] target;
    logic        rsp_take;
    logic        consume;

    // Issue is gated only by queue space, never by stall.
    assign imemReq  = (state_q == REQ) && !(head_vld_q && skid_vld_q);
    assign imemAddr = pc_q;
    assign target   = {PCTarget[31:2], 2'b00};
    assign rsp_take = (state_q == WAIT) && imemRValid && !discard_q && !redirect;
    assign consume  = head_vld_q && !stall;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        req_pc_d  = req_pc_q;
        discard_d = discard_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imemReq && imemGnt) begin
                    state_d  = WAIT;
                    req_pc_d = pc_q;
                    if (redirect) discard_d = 1'b1;
                    else          pc_d      = pc_q + 32'd4;
                end
            end
            WAIT: begin
                if (imemRValid) begin
                    state_d   = REQ;
                    discard_d = 1'b0;
                end else if (redirect) begin
                    discard_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (redirect) pc_d = target;
    end

    always_comb begin
        head_vld_d   = head_vld_q;
        head_instr_d = head_instr_q;
        head_pc_d    = head_pc_q;
        skid_vld_d   = skid_vld_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        if (redirect) begin
            head_vld_d   = 1'b0;
            head_instr_d = NOP_INSTR;
            skid_vld_d   = 1'b0;
        end else if (consume) begin
            if (skid_vld_q) begin
                head_instr_d = skid_instr_q;
                head_pc_d    = skid_pc_q;
                skid_vld_d   = rsp_take;
                skid_instr_d = imemRData;
                skid_pc_d    = req_pc_q;
            end else if (rsp_take) begin
                head_instr_d = imemRData;
                head_pc_d    = req_pc_q;
            end else begin
                head_vld_d   = 1'b0;
                head_instr_d = NOP_INSTR;
            end
        end else if (rsp_take) begin
            if (!head_vld_q) begin
                head_vld_d   = 1'b1;
                head_instr_d = imemRData;
                head_pc_d    = req_pc_q;
            end else begin
                skid_vld_d   = 1'b1;
                skid_instr_d = imemRData;
                skid_pc_d    = req_pc_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            req_pc_q     <= RESET_PC;
            discard_q    <= 1'b0;
            head_vld_q   <= 1'b0;
            head_instr_q <= NOP_INSTR;
            head_pc_q    <= RESET_PC;
            skid_vld_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            discard_q    <= discard_d;
            head_vld_q   <= head_vld_d;
            head_instr_q <= head_instr_d;
            head_pc_q    <= head_pc_d;
            skid_vld_q   <= skid_vld_d;
        end
    end

    // Skid payload is qualified by skid_vld_q, so it needs no reset.
    always_ff @(posedge clk) begin
        skid_instr_q <= skid_instr_d;
        skid_pc_q    <= skid_pc_d;
    end

    assign instrValid = head_vld_q;
    assign instr      = head_instr_q;
    assign instrPC    = head_pc_q;
    assign OPCode     = head_instr_q[6:0];
    assign funct3     = head_instr_q[14:12];
    assign funct7     = head_instr_q[30];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: programmable imem model, directed phases, and a
// scoreboard monitor that checks every instruction consumed by decode.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] PCTarget = 32'd0;
    logic        stall = 1'b0;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemGnt;
    logic        imemRValid;
    logic [31:0] imemRData;
    logic        instrValid;
    logic [31:0] instr;
    logic [31:0] instrPC;
    logic [6:0]  OPCode;
    logic [2:0]  funct3;
    logic        funct7;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;
    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    int          gnt_limit = 0;
    int          gnt_count = 0;
    int          lat       = 1;
    int          pend_cnt  = 0;
    logic [31:0] pend_addr = 32'd0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .redirect   (redirect),
        .PCTarget   (PCTarget),
        .stall      (stall),
        .imemReq    (imemReq),
        .imemAddr   (imemAddr),
        .imemGnt    (imemGnt),
        .imemRValid (imemRValid),
        .imemRData  (imemRData),
        .instrValid (instrValid),
        .instr      (instr),
        .instrPC    (instrPC),
        .OPCode     (OPCode),
        .funct3     (funct3),
        .funct7     (funct7)
    );

    // Memory: grants while under gnt_limit, answers 'lat' cycles after grant.
    assign imemGnt    = imemReq && (gnt_count < gnt_limit);
    assign imemRValid = (pend_cnt == 1);
    assign imemRData  = pend_addr ^ 32'h4000_7033;

    always @(posedge clk) begin
        if (rst) begin
            pend_cnt  <= 0;
            gnt_count <= 0;
        end else begin
            if (pend_cnt > 0) pend_cnt <= pend_cnt - 1;
            if (imemReq && imemGnt) begin
                pend_cnt  <= lat;
                pend_addr <= imemAddr;
                gnt_count <= gnt_count + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] ins);
        exp_t e;
        e.pc  = pc;
        e.ins = ins;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at #1 into cycle 0 (first cycle after release).
    task automatic do_reset();
        rst = 1'b1; redirect = 1'b0; PCTarget = 32'd0; stall = 1'b0;
        gnt_limit = 0; lat = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain(input string nm);
        int k = 0;
        while (sb.size() != 0 && k < 40) begin
            step();
            k++;
        end
        chk(nm, 32'(sb.size()), 32'd0);
        repeat (4) step();
    endtask

    // Monitor: every instruction decode accepts must be the next expected one.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && instrValid === 1'b1 && stall === 1'b0) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL mon_unexpected: got pc=%h instr=%h expected none", instrPC, instr);
                end else begin
                    e = sb.pop_front();
                    chk("mon_pc",     instrPC, e.pc);
                    chk("mon_instr",  instr, e.ins);
                    chk("mon_opcode", 32'(OPCode), 32'(e.ins[6:0]));
                    chk("mon_funct3", 32'(funct3), 32'(e.ins[14:12]));
                    chk("mon_funct7", 32'(funct7), 32'(e.ins[30]));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Zero-wait memory, stall=0
        do_reset();
        gnt_limit = 3; lat = 1;
        push(32'h0, 32'h4000_7033);
        push(32'h4, 32'h4000_7037);
        push(32'h8, 32'h4000_703B);
        chk("rst_req",    32'(imemReq), 32'd0);
        chk("rst_addr",   imemAddr, 32'd0);
        chk("rst_vld",    32'(instrValid), 32'd0);
        chk("rst_instr",  instr, NOP);
        chk("rst_pc",     instrPC, 32'd0);
        chk("rst_opcode", 32'(OPCode), 32'h13);
        step();
        chk("a_c1_req",  32'(imemReq), 32'd1);
        chk("a_c1_addr", imemAddr, 32'h0);
        step();
        chk("a_c2_req",  32'(imemReq), 32'd0);
        chk("a_c2_vld",  32'(instrValid), 32'd0);
        step();
        chk("a_c3_vld",  32'(instrValid), 32'd1);
        chk("a_c3_pc",   instrPC, 32'h0);
        chk("a_c3_req",  32'(imemReq), 32'd1);
        chk("a_c3_addr", imemAddr, 32'h4);
        step();
        chk("a_c4_req",  32'(imemReq), 32'd0);
        step();
        chk("a_c5_req",  32'(imemReq), 32'd1);
        chk("a_c5_addr", imemAddr, 32'h8);
        chk("a_c5_pc",   instrPC, 32'h4);
        drain("a_drain");
        chk("a_idle_req",  32'(imemReq), 32'd1);
        chk("a_idle_addr", imemAddr, 32'hC);

        // Stall held: two words buffered, then issue stops
        do_reset();
        gnt_limit = 3; lat = 1; stall = 1'b1;
        push(32'h0, 32'h4000_7033);
        push(32'h4, 32'h4000_7037);
        push(32'h8, 32'h4000_703B);
        repeat (5) step();
        for (int i = 5; i <= 10; i++) begin
            chk("b_hold_req", 32'(imemReq), 32'd0);
            chk("b_hold_pc",  instrPC, 32'h0);
            if (i < 10) step();
        end
        chk("b_hold_vld", 32'(instrValid), 32'd1);
        stall = 1'b0;
        step();
        chk("b_rel_pc",   instrPC, 32'h4);
        chk("b_rel_req",  32'(imemReq), 32'd1);
        chk("b_rel_addr", imemAddr, 32'h8);
        drain("b_drain");

        // Redirect while WAIT, response arrives two cycles later
        do_reset();
        gnt_limit = 2; lat = 3;
        push(32'h100, 32'h4000_7133);
        step();
        chk("c_c1_req", 32'(imemReq), 32'd1);
        step();
        redirect = 1'b1; PCTarget = 32'h0000_0102;
        step();
        redirect = 1'b0;
        chk("c_c3_vld",  32'(instrValid), 32'd0);
        chk("c_c3_req",  32'(imemReq), 32'd0);
        chk("c_c3_addr", imemAddr, 32'h100);
        step();
        chk("c_c4_req",  32'(imemReq), 32'd0);
        step();
        chk("c_c5_req",  32'(imemReq), 32'd1);
        chk("c_c5_addr", imemAddr, 32'h100);
        step();
        chk("c_c6_vld",  32'(instrValid), 32'd0);
        drain("c_drain");

        // Redirect in the same cycle as the response
        do_reset();
        gnt_limit = 2; lat = 1;
        push(32'h200, 32'h4000_7233);
        step();
        step();
        redirect = 1'b1; PCTarget = 32'h0000_0200;
        step();
        redirect = 1'b0;
        chk("d_c3_req",  32'(imemReq), 32'd1);
        chk("d_c3_addr", imemAddr, 32'h200);
        chk("d_c3_vld",  32'(instrValid), 32'd0);
        drain("d_drain");

        // Grant withheld, redirect while requesting
        do_reset();
        lat = 1;
        push(32'h300, 32'h4000_7333);
        step();
        chk("e_c1_addr", imemAddr, 32'h0);
        step();
        chk("e_c2_addr", imemAddr, 32'h0);
        step();
        chk("e_c3_req",  32'(imemReq), 32'd1);
        chk("e_c3_addr", imemAddr, 32'h0);
        redirect = 1'b1; PCTarget = 32'h0000_0300;
        step();
        redirect = 1'b0;
        chk("e_c4_req",  32'(imemReq), 32'd1);
        chk("e_c4_addr", imemAddr, 32'h300);
        step();
        chk("e_c5_addr", imemAddr, 32'h300);
        gnt_limit = 1;
        drain("e_drain");

        // Redirect in REQ together with grant: word discarded, pc not bumped
        do_reset();
        gnt_limit = 2; lat = 1;
        push(32'h400, 32'h4000_7433);
        step();
        redirect = 1'b1; PCTarget = 32'h0000_0400;
        step();
        redirect = 1'b0;
        chk("g_c2_req",  32'(imemReq), 32'd0);
        chk("g_c2_addr", imemAddr, 32'h400);
        step();
        chk("g_c3_req",  32'(imemReq), 32'd1);
        chk("g_c3_addr", imemAddr, 32'h400);
        drain("g_drain");

        // PC wrap at top of memory, then async reset mid-WAIT
        do_reset();
        stall = 1'b1;
        step();
        redirect = 1'b1; PCTarget = 32'hFFFF_FFFF;
        step();
        redirect = 1'b0;
        chk("f_c2_req",  32'(imemReq), 32'd1);
        chk("f_c2_addr", imemAddr, 32'hFFFF_FFFC);
        gnt_limit = 2; lat = 1;
        step();
        chk("f_c3_req",  32'(imemReq), 32'd0);
        chk("f_c3_addr", imemAddr, 32'h0);
        lat = 5;
        step();
        chk("f_c4_vld",  32'(instrValid), 32'd1);
        chk("f_c4_pc",   instrPC, 32'hFFFF_FFFC);
        chk("f_c4_req",  32'(imemReq), 32'd1);
        chk("f_c4_addr", imemAddr, 32'h0);
        step();
        chk("f_c5_req",   32'(imemReq), 32'd0);
        chk("f_c5_addr",  imemAddr, 32'h4);
        chk("f_c5_instr", instr, 32'hBFFF_8FCF);
        #2;
        rst = 1'b1;
        #1;
        chk("f_arst_req",    32'(imemReq), 32'd0);
        chk("f_arst_addr",   imemAddr, 32'h0);
        chk("f_arst_vld",    32'(instrValid), 32'd0);
        chk("f_arst_instr",  instr, NOP);
        chk("f_arst_pc",     instrPC, 32'h0);
        chk("f_arst_opcode", 32'(OPCode), 32'h13);
        chk("f_arst_funct3", 32'(funct3), 32'd0);
        chk("f_arst_funct7", 32'(funct7), 32'd0);
        step();

        chk("sb_empty_end", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
